// File: rtl/mem_bus_master_if.sv
// Request/response handshake and Avalon-MM bus signals of mem_bus_master.
// The master modport is the block's view; slave is the CPU-control/memory side.
interface mem_bus_master_if;
  // CPU-side request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // CPU-side response
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // Avalon-MM bus
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  avm_address, avm_read, avm_write, avm_byteenable, avm_writedata
  );
endinterface

// File: rtl/mem_bus_master.sv
// Memory-side bus master for the multicycle MIPS CPU. Runs one fetch/load/store
// as a single Avalon-MM transfer, aligns store lanes, extends load data and
// returns a one-cycle response pulse.
module mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              reset_n,
  mem_bus_master_if.master bus
);

  // Counter only needs to reach TIMEOUT_CYCLES; keep at least one bit when disabled.
  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;
  localparam logic [1:0] SzWord = 2'd2;

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  state_e          state_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [31:0]     rsp_rdata_q;
  logic [31:0]     avm_address_q;
  logic            avm_read_q;
  logic            avm_write_q;
  logic [3:0]      avm_be_q;
  logic [31:0]     avm_wdata_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [1:0]      lane_q;

  logic            req_bad;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [31:0]     ld_data;
  logic [CntW-1:0] wait_next;
  logic            timeout_hit;

  // Decode the incoming request: legality, store byte lanes and replicated data.
  always_comb begin
    req_bad  = 1'b0;
    st_be    = 4'b1111;
    st_wdata = bus.req_wdata;
    case (bus.req_size)
      SzByte: begin
        st_be    = 4'b0001 << bus.req_addr[1:0];
        st_wdata = {4{bus.req_wdata[7:0]}};
      end
      SzHalf: begin
        req_bad  = bus.req_addr[0];
        st_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.req_wdata[15:0]}};
      end
      SzWord:  req_bad = |bus.req_addr[1:0];
      default: req_bad = 1'b1;
    endcase
  end

  // Extract and extend load data from the lane captured at acceptance.
  always_comb begin
    ld_byte = 8'(bus.avm_readdata >> {lane_q, 3'b000});
    ld_half = 16'(bus.avm_readdata >> {lane_q[1], 4'b0000});
    case (size_q)
      SzByte:  ld_data = unsigned_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SzHalf:  ld_data = unsigned_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = bus.avm_readdata;
    endcase
  end

  assign wait_next   = wait_cnt_q + CntW'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_next == CntW'(TIMEOUT_CYCLES));

  // Transfer FSM; every output is a register so strobes drop at once on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      avm_address_q <= '0;
      avm_read_q    <= 1'b0;
      avm_write_q   <= 1'b0;
      avm_be_q      <= '0;
      avm_wdata_q   <= '0;
      wait_cnt_q    <= '0;
      size_q        <= '0;
      unsigned_q    <= 1'b0;
      lane_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!req_ready_q) begin
            // First cycle after reset: advertise readiness before accepting.
            req_ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            size_q      <= bus.req_size;
            unsigned_q  <= bus.req_unsigned;
            lane_q      <= bus.req_addr[1:0];
            if (req_bad) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q       <= StBus;
              wait_cnt_q    <= '0;
              avm_address_q <= {bus.req_addr[31:2], 2'b00};
              avm_read_q    <= !bus.req_write;
              avm_write_q   <= bus.req_write;
              avm_be_q      <= bus.req_write ? st_be : 4'b1111;
              avm_wdata_q   <= bus.req_write ? st_wdata : 32'h0;
            end
          end
        end
        StBus: begin
          if (!bus.avm_waitrequest) begin
            state_q     <= StResp;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= avm_read_q ? ld_data : 32'h0;
          end else if (timeout_hit) begin
            state_q     <= StResp;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end else begin
            wait_cnt_q <= wait_next;
          end
        end
        StResp: begin
          state_q     <= StIdle;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_byteenable = avm_be_q;
  assign bus.avm_writedata  = avm_wdata_q;

endmodule
